mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares the processor's single-ported, synchronous data memory between the core's MEM stage and a host key/plaintext loader port. Core requests normally win contested cycles; a starvation counter guarantees the host a grant after a bounded number of losses. Sits between control_unit/datapath memory signals and the data RAM; one access is in flight at a time.

## Interface
Parameters:
- ADDR_W, 8, memory address width
- DATA_W, 8, memory data width
- STARVE_LIMIT, 3, contested losses after which the host wins the next contested arbitration (≥1)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- core_req  in  1  core access request, level, held until core_gnt
- core_we  in  1  1 = write, 0 = read; stable while core_req
- core_addr  in  ADDR_W  access address; stable while core_req
- core_wdata  in  DATA_W  write data; stable while core_req
- core_gnt  out  1  one-cycle pulse: core access issued to memory
- core_rvalid  out  1  one-cycle pulse: core_rdata valid
- core_rdata  out  DATA_W  read data, valid only with core_rvalid
- host_req, host_we, host_addr, host_wdata, host_gnt, host_rvalid, host_rdata: same as core_* for the host port
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable, valid with mem_en
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid one cycle after a read strobe
- owner  out  2  00 none, 01 core, 10 host (owner of access in flight)
- busy  out  1  high when state ≠ IDLE

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: if neither req high, stay. If exactly one high, capture that port's we/addr/wdata, set owner, go ACCESS. If both high: host wins iff host_wait == STARVE_LIMIT, else core wins.
- host_wait: increments in IDLE when both req high and core wins; saturates at STARVE_LIMIT; clears to 0 whenever host is granted. Never changes outside IDLE.
- ACCESS: mem_en=1, mem_we/addr/wdata from captured copy; owner's gnt=1. Write → IDLE. Read → RESP.
- RESP: owner's rvalid=1, owner's rdata = mem_rdata (combinational pass-through); → IDLE.
- Requests are ignored in ACCESS and RESP; arbitration only in IDLE.
- Requester drops req in the cycle after its gnt; a req still high in IDLE is a new request.
- Non-owner gnt/rvalid stay 0; rdata on the idle port is 0.
- mem_addr/mem_wdata/mem_we are 0 when mem_en=0.

## Timing
- Reset values: all outputs 0, state IDLE, owner 00, host_wait 0, captured request cleared.
- Request seen in IDLE at cycle T → gnt + mem_en at T+1 → (read) rvalid at T+2 → IDLE at T+2 (write) / T+3 (read).
- Throughput: back-to-back writes every 2 cycles, reads every 3.
- Reset asserted in ACCESS or RESP: next cycle IDLE, access abandoned, no gnt/rvalid emitted afterwards; the memory write in an ACCESS cycle coinciding with reset is not issued (mem_en gated by reset).
- Both req rising in the same IDLE cycle are a contested arbitration; a loser keeps its req and is re-arbitrated in the next IDLE cycle.
- STARVE_LIMIT=3: host loses at most 3 contested arbitrations in a row.

## Structure
- Shared package (crypto_pkg): arbiter state encoding (IDLE/ACCESS/RESP) and owner encoding (NONE/CORE/HOST) as localparams, alongside existing control-unit state codes.
- One natural sub-module: arb_starve_ctr (saturating host_wait counter with clear and limit-reached flag); remainder in mem_port_arbiter.

## Test plan
- Core read only: core_req, addr=0x10, mem holds 0xA5 → core_gnt at T+1, mem_en=1 mem_we=0 mem_addr=0x10, core_rvalid at T+2 with core_rdata=0xA5, busy low at T+3.
- Host write only: host_we=1, addr=0x20, wdata=0x3C → T+1 mem_en=1 mem_we=1 mem_addr=0x20 mem_wdata=0x3C, host_gnt=1; IDLE at T+2; readback returns 0x3C.
- Contested, STARVE_LIMIT=3: core and host request continuously → grants core, core, core, host, then repeat; host_wait returns to 0 after host grant.
- Simultaneous first request, host_wait=0 → core granted first, host granted on next IDLE arbitration if core_req dropped.
- Reset during RESP of a core read → no core_rvalid, all outputs 0 next cycle, owner 00, host_wait 0.
- Reset during ACCESS of a host write → mem_en never seen high in that cycle; memory location keeps old value.

Source files
------------

// File: rtl/crypto_pkg.sv
// Shared encodings: control-unit state codes plus memory port arbiter state/owner codes.
package crypto_pkg;

  // Control-unit sequencing states.
  typedef enum logic [2:0] {
    CU_FETCH  = 3'd0,
    CU_DECODE = 3'd1,
    CU_EXEC   = 3'd2,
    CU_MEM    = 3'd3,
    CU_WB     = 3'd4
  } cu_state_e;

  // Memory port arbiter state codes.
  localparam logic [1:0] ARB_IDLE_CODE   = 2'd0;
  localparam logic [1:0] ARB_ACCESS_CODE = 2'd1;
  localparam logic [1:0] ARB_RESP_CODE   = 2'd2;

  typedef enum logic [1:0] {
    ARB_IDLE   = ARB_IDLE_CODE,
    ARB_ACCESS = ARB_ACCESS_CODE,
    ARB_RESP   = ARB_RESP_CODE
  } arb_state_e;

  // Owner of the access in flight.
  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_CORE = 2'b01;
  localparam logic [1:0] OWNER_HOST = 2'b10;

  function automatic logic [1:0] owner_code(input logic is_host);
    return is_host ? OWNER_HOST : OWNER_CORE;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side memory port: level request with captured command, grant and read-response pulses.
//   master: requester (drives req/we/addr/wdata, receives gnt/rvalid/rdata)
//   slave : arbiter   (receives the request, drives gnt/rvalid/rdata)
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, output we, output addr, output wdata,
                  input gnt, input rvalid, input rdata);
  modport slave  (input req, input we, input addr, input wdata,
                  output gnt, output rvalid, output rdata);
endinterface

// File: rtl/mem_port_arbiter_starve_ctr.sv
// arb_starve_ctr: saturating count of contested arbitrations the host has lost.
//   clk, reset : clock, synchronous active-high reset
//   inc        : host lost a contested arbitration this cycle
//   clr        : host granted this cycle (dominates inc)
//   at_limit   : count has reached STARVE_LIMIT, host wins the next contest
module arb_starve_ctr #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] host_wait;

  always_ff @(posedge clk) begin
    if (reset) begin
      host_wait <= '0;
    end else if (clr) begin
      host_wait <= '0;
    end else if (inc && (host_wait != CNT_W'(STARVE_LIMIT))) begin
      host_wait <= host_wait + CNT_W'(1);
    end
  end

  assign at_limit = (host_wait == CNT_W'(STARVE_LIMIT));
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous single-port data RAM between the core MEM
// stage and the host loader; one access in flight, core preferred, host starvation bounded.
//   clk, reset        : clock, synchronous active-high reset
//   core, host        : requester ports (slave side of mem_port_arbiter_if)
//   mem_en/we/addr/wdata : RAM command, zeroed when mem_en is low
//   mem_rdata         : RAM read data, one cycle after a read strobe
//   owner             : 00 none, 01 core, 10 host
//   busy              : arbiter not idle
module mem_port_arbiter
  import crypto_pkg::*;
#(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave core,
  mem_port_arbiter_if.slave host,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner,
  output logic              busy
);
  arb_state_e        state;
  logic [1:0]        owner_q;
  logic              cap_we;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  logic              mem_en_q;
  logic              core_gnt_q, host_gnt_q;
  logic              core_rvalid_q, host_rvalid_q;
  logic              busy_q;

  logic host_at_limit;
  logic host_win_c, core_win_c;
  logic arb_c;
  logic core_rvalid_c, host_rvalid_c;

  // Host takes a contested cycle only once it has lost STARVE_LIMIT times in a row.
  assign arb_c      = (state == ARB_IDLE);
  assign host_win_c = host.req & (~core.req | host_at_limit);
  assign core_win_c = core.req & ~host_win_c;

  arb_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
    .clk      (clk),
    .reset    (reset),
    .inc      (arb_c & host.req & core_win_c),
    .clr      (arb_c & host_win_c),
    .at_limit (host_at_limit)
  );

  // Arbitration / access sequencing with registered pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ARB_IDLE;
      owner_q       <= OWNER_NONE;
      cap_we        <= 1'b0;
      cap_addr      <= '0;
      cap_wdata     <= '0;
      mem_en_q      <= 1'b0;
      core_gnt_q    <= 1'b0;
      host_gnt_q    <= 1'b0;
      core_rvalid_q <= 1'b0;
      host_rvalid_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      mem_en_q      <= 1'b0;
      core_gnt_q    <= 1'b0;
      host_gnt_q    <= 1'b0;
      core_rvalid_q <= 1'b0;
      host_rvalid_q <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (host_win_c || core_win_c) begin
            state    <= ARB_ACCESS;
            busy_q   <= 1'b1;
            mem_en_q <= 1'b1;
            owner_q  <= owner_code(host_win_c);
            if (host_win_c) begin
              host_gnt_q <= 1'b1;
              cap_we     <= host.we;
              cap_addr   <= host.addr;
              cap_wdata  <= host.wdata;
            end else begin
              core_gnt_q <= 1'b1;
              cap_we     <= core.we;
              cap_addr   <= core.addr;
              cap_wdata  <= core.wdata;
            end
          end
        end
        ARB_ACCESS: begin
          if (cap_we) begin
            state   <= ARB_IDLE;
            owner_q <= OWNER_NONE;
            busy_q  <= 1'b0;
          end else begin
            state         <= ARB_RESP;
            core_rvalid_q <= (owner_q == OWNER_CORE);
            host_rvalid_q <= (owner_q == OWNER_HOST);
          end
        end
        default: begin
          state   <= ARB_IDLE;
          owner_q <= OWNER_NONE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Reset abandons an access in the same cycle: no strobe, grant or response escapes.
  assign mem_en    = mem_en_q & ~reset;
  assign mem_we    = mem_en & cap_we;
  assign mem_addr  = mem_en ? cap_addr  : '0;
  assign mem_wdata = mem_en ? cap_wdata : '0;

  assign core_rvalid_c = core_rvalid_q & ~reset;
  assign host_rvalid_c = host_rvalid_q & ~reset;

  assign core.gnt    = core_gnt_q & ~reset;
  assign host.gnt    = host_gnt_q & ~reset;
  assign core.rvalid = core_rvalid_c;
  assign host.rvalid = host_rvalid_c;
  assign core.rdata  = core_rvalid_c ? mem_rdata : '0;
  assign host.rdata  = host_rvalid_c ? mem_rdata : '0;

  assign owner = owner_q;
  assign busy  = busy_q;
endmodule
